// File: rtl/clint_pkg.sv
// clint_pkg: CLINT address map constants, register widths and the address decoder
package clint_pkg;
  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;
  localparam int XLEN    = 32;
  localparam int MTIME_W = 64;
  typedef enum logic [1:0] {RGN_NONE, RGN_MSIP, RGN_MTIMECMP, RGN_MTIME} region_e;
  typedef struct packed {
    region_e    region;
    logic [3:0] hart;
    logic       hi;
  } dec_t;
  // Hart indices are decoded for the full 16-hart window; the top level only
  // builds slots for harts that exist, so absent harts read 0 and ignore writes.
  function automatic dec_t clint_decode(input logic [15:0] addr);
    dec_t d;
    logic [15:0] wa;
    wa       = {addr[15:2], 2'b00};
    d.region = RGN_NONE;
    d.hart   = 4'd0;
    d.hi     = addr[2];
    if (wa[15:6] == CLINT_MSIP_BASE[15:6]) begin
      d.region = RGN_MSIP;
      d.hart   = wa[5:2];
    end else if (wa[15:7] == CLINT_MTIMECMP_BASE[15:7]) begin
      d.region = RGN_MTIMECMP;
      d.hart   = wa[6:3];
    end else if (wa == CLINT_MTIME_LO || wa == CLINT_MTIME_HI) begin
      d.region = RGN_MTIME;
    end
    return d;
  endfunction
endpackage

// File: rtl/clint_hart_slot.sv
// clint_hart_slot: per-hart mtimecmp, msip and registered mtip
//   CLK, RST_X                      clock, async active-low reset
//   msip_we, cmp_lo_we, cmp_hi_we   decoded write strobes
//   msip_re, cmp_lo_re, cmp_hi_re   decoded read selects
//   wdata, mtime                    write data, current mtime
//   rdata, mtip, msip               read mux data, interrupt outputs
module clint_hart_slot
  import clint_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               msip_we,
  input  logic               cmp_lo_we,
  input  logic               cmp_hi_we,
  input  logic               msip_re,
  input  logic               cmp_lo_re,
  input  logic               cmp_hi_re,
  input  logic [XLEN-1:0]    wdata,
  input  logic [MTIME_W-1:0] mtime,
  output logic [XLEN-1:0]    rdata,
  output logic               mtip,
  output logic               msip
);
  logic [MTIME_W-1:0] mtimecmp;
  // mtip compares the current flops, so it trails the compare condition by one cycle
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      if (cmp_lo_we) mtimecmp[31:0] <= wdata;
      if (cmp_hi_we) mtimecmp[63:32] <= wdata;
      if (msip_we) msip <= wdata[0];
      mtip <= mtime >= mtimecmp;
    end
  end
  assign rdata = msip_re   ? {31'b0, msip} :
                 cmp_lo_re ? mtimecmp[31:0] :
                 cmp_hi_re ? mtimecmp[63:32] : '0;
endmodule

// File: rtl/clint_smp.sv
// clint_smp: core-local interruptor with mtime, per-hart mtimecmp/msip and a req/ack register port
//   CLK, RST_X                 clock, async active-low reset
//   w_req, w_we, w_addr, w_wdata   register access request (one-cycle pulse)
//   w_rdata, w_ack             response, one cycle after the request
//   w_mtip, w_msip, w_mtime    per-hart interrupts and the shared mtime bus
module clint_smp
  import clint_pkg::*;
#(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_req,
  input  logic               w_we,
  input  logic [15:0]        w_addr,
  input  logic [XLEN-1:0]    w_wdata,
  output logic [XLEN-1:0]    w_rdata,
  output logic               w_ack,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [MTIME_W-1:0] w_mtime
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  dec_t            dec;
  logic [PW-1:0]   presc;
  logic            tick, wr, rd, mt_sel, mt_lo_we, mt_hi_we;
  logic [XLEN-1:0] slot_rd [N_HARTS];
  logic [XLEN-1:0] slot_or, rd_mux;
  assign dec      = clint_decode(w_addr);
  assign tick     = presc == PW'(TICK_DIV - 1);
  assign wr       = w_req & w_we;
  assign rd       = w_req & ~w_we;
  assign mt_sel   = dec.region == RGN_MTIME;
  assign mt_lo_we = wr & mt_sel & ~dec.hi;
  assign mt_hi_we = wr & mt_sel & dec.hi;
  always_comb begin
    slot_or = '0;
    for (int i = 0; i < N_HARTS; i++) slot_or = slot_or | slot_rd[i];
  end
  assign rd_mux = mt_sel ? (dec.hi ? w_mtime[63:32] : w_mtime[31:0]) : slot_or;
  // A write to either mtime half replaces that half and suppresses the tick's
  // increment entirely; the prescaler keeps running regardless.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      presc   <= '0;
      w_mtime <= '0;
      w_ack   <= 1'b0;
      w_rdata <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      w_mtime <= mt_lo_we ? {w_mtime[63:32], w_wdata} :
                 mt_hi_we ? {w_wdata, w_mtime[31:0]} :
                 tick     ? w_mtime + 64'd1 : w_mtime;
      w_ack   <= w_req;
      w_rdata <= rd ? rd_mux : '0;
    end
  end
  for (genvar h = 0; h < N_HARTS; h++) begin : g_slot
    logic hsel, msip_sel, cmp_sel;
    assign hsel     = dec.hart == 4'(h);
    assign msip_sel = hsel & (dec.region == RGN_MSIP);
    assign cmp_sel  = hsel & (dec.region == RGN_MTIMECMP);
    clint_hart_slot u_slot (
      .CLK       (CLK),
      .RST_X     (RST_X),
      .msip_we   (wr & msip_sel),
      .cmp_lo_we (wr & cmp_sel & ~dec.hi),
      .cmp_hi_we (wr & cmp_sel & dec.hi),
      .msip_re   (msip_sel),
      .cmp_lo_re (cmp_sel & ~dec.hi),
      .cmp_hi_re (cmp_sel & dec.hi),
      .wdata     (w_wdata),
      .mtime     (w_mtime),
      .rdata     (slot_rd[h]),
      .mtip      (w_mtip[h]),
      .msip      (w_msip[h])
    );
  end
endmodule

// File: tb/tb_clint_smp.sv
// tb_clint_smp: directed self-checking bench for clint_smp (TICK_DIV=1 and TICK_DIV=4 instances)
module tb_clint_smp;
  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;
  logic        req1, we1, req4, we4;
  logic [15:0] addr1, addr4;
  logic [31:0] wd1, wd4, rdata1, rdata4;
  logic        ack1, ack4;
  logic [1:0]  mtip1, msip1, mtip4, msip4;
  logic [63:0] mtime1, mtime4;
  int n_chk = 0;
  int n_fail = 0;
  int unsigned ecnt;
  clint_smp #(.N_HARTS(2), .TICK_DIV(1)) dut1 (
    .CLK(CLK), .RST_X(RST_X), .w_req(req1), .w_we(we1), .w_addr(addr1), .w_wdata(wd1),
    .w_rdata(rdata1), .w_ack(ack1), .w_mtip(mtip1), .w_msip(msip1), .w_mtime(mtime1)
  );
  clint_smp #(.N_HARTS(2), .TICK_DIV(4)) dut4 (
    .CLK(CLK), .RST_X(RST_X), .w_req(req4), .w_we(we4), .w_addr(addr4), .w_wdata(wd4),
    .w_rdata(rdata4), .w_ack(ack4), .w_mtip(mtip4), .w_msip(msip4), .w_mtime(mtime4)
  );
  // edges since reset release; every 4th edge is a tick of the TICK_DIV=4 instance
  always @(posedge CLK or negedge RST_X) ecnt <= !RST_X ? 0 : ecnt + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit d4, input logic r, input logic we, input logic [15:0] a, input logic [31:0] wd);
    if (d4) begin req4 = r; we4 = we; addr4 = a; wd4 = wd; end
    else begin req1 = r; we1 = we; addr1 = a; wd1 = wd; end
  endtask
  task automatic acc(input bit d4, input logic we, input logic [15:0] a, input logic [31:0] wd);
    @(posedge CLK); #1;
    drive(d4, 1'b1, we, a, wd);
    @(posedge CLK); #1;
    drive(d4, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    #2;
    chk("rst_mtime1", mtime1, 64'd0);
    chk("rst_mtime4", mtime4, 64'd0);
    chk("rst_irq", {mtip1, msip1}, 4'b0);
    chk("rst_ack_rdata", {ack1, rdata1}, 33'd0);
    @(negedge CLK);
    RST_X = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      chk("mtime_div1", mtime1, 64'(k));
      chk("mtime_div4", mtime4, 64'(k / 4));
      chk("idle_irq", {mtip1, msip1}, 4'b0);
    end
    acc(0, 0, 16'h4000, 0);
    chk("rd_cmp0_lo", {ack1, rdata1}, {1'b1, 32'hFFFF_FFFF});
    @(posedge CLK); #1;
    chk("ack_drop", {ack1, rdata1}, 33'd0);
    acc(0, 1, 16'hBFF8, 32'd90);
    acc(0, 1, 16'h4008, 32'd100);
    acc(0, 1, 16'h400C, 32'd0);
    begin
      int w = 0;
      while (mtime1 != 64'd100 && w < 50) begin
        @(posedge CLK); #1;
        w++;
      end
      chk("reach_100", mtime1, 64'd100);
    end
    chk("mtip_before", mtip1, 2'b00);
    @(posedge CLK); #1;
    chk("mtip_rise", mtip1, 2'b10);
    acc(0, 1, 16'h400C, 32'd1);
    @(posedge CLK); #1;
    chk("mtip_clear", mtip1, 2'b00);
    acc(0, 1, 16'h0004, 32'hFFFF_FFFF);
    chk("msip_set", msip1, 2'b10);
    acc(0, 0, 16'h0004, 0);
    chk("rd_msip1", {ack1, rdata1}, {1'b1, 32'd1});
    acc(0, 1, 16'h0004, 32'd0);
    chk("msip_clr", msip1, 2'b00);
    acc(0, 1, 16'h0008, 32'hFFFF_FFFF);
    chk("absent_wr", {ack1, msip1}, 3'b100);
    acc(0, 0, 16'h0008, 0);
    chk("absent_rd_msip", {ack1, rdata1}, {1'b1, 32'd0});
    acc(0, 0, 16'h4010, 0);
    chk("absent_rd_cmp", {ack1, rdata1}, {1'b1, 32'd0});
    acc(0, 1, 16'hBFFC, 32'hFFFF_FFFF);
    acc(0, 1, 16'hBFF8, 32'hFFFF_FFFE);
    chk("wrap_m2", mtime1, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge CLK); #1;
    chk("wrap_m1", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge CLK); #1;
    chk("wrap_0", mtime1, 64'd0);
    acc(0, 1, 16'hBFFC, 32'd5);
    @(posedge CLK); #1;
    drive(0, 1, 1, 16'hBFF8, 32'h10);
    @(posedge CLK); #1;
    drive(0, 1, 0, 16'hBFF8, 0);
    @(posedge CLK); #1;
    drive(0, 1, 0, 16'hBFFC, 0);
    chk("b2b_lo", {ack1, rdata1}, {1'b1, 32'h10});
    @(posedge CLK); #1;
    drive(0, 1, 0, 16'h1234, 0);
    chk("b2b_hi", {ack1, rdata1}, {1'b1, 32'd5});
    @(posedge CLK); #1;
    drive(0, 0, 0, 0, 0);
    chk("b2b_unmapped", {ack1, rdata1}, {1'b1, 32'd0});
    @(posedge CLK); #1;
    chk("b2b_end", {ack1, rdata1}, 33'd0);
    acc(1, 1, 16'hBFFC, 32'd0);
    acc(1, 1, 16'hBFF8, 32'hFFFF_FFFF);
    chk("div4_lo_wr", mtime4, 64'h0000_0000_FFFF_FFFF);
    repeat (4) @(posedge CLK);
    #1;
    chk("div4_carry", mtime4, 64'h1_0000_0000);
    begin
      int w = 0;
      while (ecnt % 4 != 3 && w < 8) begin
        @(posedge CLK); #1;
        w++;
      end
    end
    drive(1, 1, 1, 16'hBFF8, 32'h123);
    @(posedge CLK); #1;
    drive(1, 0, 0, 0, 0);
    chk("tick_wr_held", mtime4, 64'h1_0000_0123);
    repeat (3) @(posedge CLK);
    #1;
    chk("tick_wr_hold3", mtime4, 64'h1_0000_0123);
    @(posedge CLK); #1;
    chk("tick_wr_next", mtime4, 64'h1_0000_0124);
    acc(0, 1, 16'h400C, 32'd0);
    acc(0, 1, 16'h0000, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    chk("pre_rst_irq", {mtip1, msip1}, 4'b1001);
    drive(0, 1, 0, 16'h4008, 0);
    @(posedge CLK); #1;
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_ack", {ack1, rdata1}, {1'b1, 32'd100});
    #2;
    RST_X = 1'b0;
    #1;
    chk("rst_mid_ack", {ack1, rdata1}, 33'd0);
    chk("rst_mid_irq", {mtip1, msip1}, 4'b0);
    chk("rst_mid_mtime", {mtime1, mtime4}, 128'd0);
    @(negedge CLK);
    RST_X = 1'b1;
    acc(0, 0, 16'h400C, 0);
    chk("rst_cmp1_hi", {ack1, rdata1}, {1'b1, 32'hFFFF_FFFF});
    acc(0, 0, 16'h4008, 0);
    chk("rst_cmp1_lo", {ack1, rdata1}, {1'b1, 32'hFFFF_FFFF});
    chk("rst_mtip", mtip1, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
